// File: rtl/reg_bank_loader.sv
// rtl/reg_bank_loader.sv - burst load sequencer driving a one-hot Ld vector into a register bank
//
// Purpose:
//   Takes a burst of NUM_REGS words from a valid/ready stream. Word k is written
//   into register k by pulsing o_ld[k] while o_data_out carries the word. After
//   the last word, o_done pulses for one cycle.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_start      begin a burst; only sampled in IDLE
//   i_abort      cancel the burst in progress (wins over i_start in IDLE)
//   i_in_valid   i_in_data holds a valid word
//   i_in_data    word to write
//   o_in_ready   a word is accepted this cycle (high only in LOAD)
//   o_ld         one-hot load strobes, registered, one per register
//   o_data_out   shared registered data bus to every register's Data_In
//   o_idx        index of the next register to be written
//   o_busy       loader is not IDLE
//   o_done       one-cycle pulse on successful completion
//   o_clr_out    bank clear strobe (only when REG_LOADER_CLR_EN is defined)
//
// Configuration:
//   REG_LOADER_CLR_EN  when defined, Start passes through a one-cycle CLEAR state
//                      that asserts o_clr_out before loading begins.

module reg_bank_loader #(
  parameter int N        = 16,
  parameter int NUM_REGS = 8
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic                        i_in_valid,
  input  logic [N-1:0]                i_in_data,
  output logic                        o_in_ready,
  output logic [NUM_REGS-1:0]         o_ld,
  output logic [N-1:0]                o_data_out,
  output logic [$clog2(NUM_REGS)-1:0] o_idx,
  output logic                        o_busy,
  output logic                        o_done
`ifdef REG_LOADER_CLR_EN
  ,
  output logic                        o_clr_out
`endif
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  // The encoding keeps CLEAR even in the default build so both builds share
  // one state register layout; the default build never enters it.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_LOAD  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [NUM_REGS-1:0]  r_ld;
  logic [N-1:0]         r_data;
  logic [IDX_W-1:0]     r_idx;

  logic                 w_in_ready;
  logic                 w_done;
  logic                 w_xfer;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_begin;
`ifdef REG_LOADER_CLR_EN
  logic                 w_clr;
`endif

  // Next-state and state-decoded outputs
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_done     = 1'b0;
    w_xfer     = 1'b0;
    w_begin    = 1'b0;
    w_last     = (r_idx == LAST_IDX);
`ifdef REG_LOADER_CLR_EN
    w_clr      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        // Abort has priority over Start so a simultaneous pair is a no-op.
        if (i_start && !i_abort) begin
          w_begin = 1'b1;
`ifdef REG_LOADER_CLR_EN
          w_next  = S_CLEAR;
`else
          w_next  = S_LOAD;
`endif
        end
      end
      S_CLEAR: begin
`ifdef REG_LOADER_CLR_EN
        // Clear is asserted for this cycle even if Abort arrives in it.
        w_clr = 1'b1;
`endif
        w_next = i_abort ? S_IDLE : S_LOAD;
      end
      S_LOAD: begin
        w_in_ready = 1'b1;
        w_xfer     = i_in_valid;
        if (i_abort) begin
          w_next = S_IDLE;
        end else if (i_in_valid && w_last) begin
          w_next = S_FIN;
        end
      end
      S_FIN: begin
        // FIN lines up with the final Ld strobe; Start here is ignored.
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // A transfer that coincides with Abort is dropped: no strobe, no index step.
  assign w_accept = w_xfer && !i_abort;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_ld    <= '0;
      r_data  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;

      // Ld is a single-cycle strobe; a strobe already on the bus is never
      // retracted by a later Abort because it was registered last cycle.
      if (w_accept) begin
        r_ld   <= NUM_REGS'(1) << r_idx;
        r_data <= i_in_data;
      end else begin
        r_ld   <= '0;
      end

      // Explicit wrap at LAST_IDX so non-power-of-two banks return to 0.
      if (w_begin) begin
        r_idx <= '0;
      end else if ((r_state != S_IDLE) && i_abort) begin
        r_idx <= '0;
      end else if (w_accept) begin
        r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  assign o_in_ready = w_in_ready;
  assign o_ld       = r_ld;
  assign o_data_out = r_data;
  assign o_idx      = r_idx;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = w_done;
`ifdef REG_LOADER_CLR_EN
  assign o_clr_out  = w_clr;
`endif

endmodule
